// File: rtl/shifter_pkg.sv
// Shared encodings and helpers for the pipelined barrel shifter.
package shifter_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_SLL = 3'b000;
  localparam logic [OP_W-1:0] OP_SRL = 3'b001;
  localparam logic [OP_W-1:0] OP_SRA = 3'b010;
  localparam logic [OP_W-1:0] OP_ROL = 3'b011;
  localparam logic [OP_W-1:0] OP_ROR = 3'b100;

  function automatic logic is_reserved_op(input logic [OP_W-1:0] op);
    return (op > OP_ROR);
  endfunction

endpackage

// File: rtl/shift_level.sv
// One barrel-shifter level: conditionally moves the operand by a fixed distance DIST.
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [OP_W-1:0]  op,
  input  logic             en,
  input  logic             sign,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data;
    if (en) begin
      case (op)
        OP_SLL:  result = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
        OP_SRL:  result = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
        // sign comes from the operand as accepted, not from this level's input
        OP_SRA:  result = {{DIST{sign}}, data[WIDTH-1:DIST]};
        OP_ROL:  result = {data[WIDTH-DIST-1:0], data[WIDTH-1:WIDTH-DIST]};
        OP_ROR:  result = {data[DIST-1:0], data[WIDTH-1:DIST]};
        default: result = data;
      endcase
    end
  end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined shift/rotate unit with valid/ready handshakes and a pass-through tag.
// PIPE=0: all levels combinational into one output register; PIPE=1: a register after every level.
module pipe_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int  WIDTH   = 32,
  parameter int  PIPE    = 0,
  parameter int  TAG_W   = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [OP_W-1:0]    in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);

  localparam int LV = SHAMT_W;

  // Index k holds the inputs of level k; index LV is the output register.
  logic [WIDTH-1:0]   d_in  [LV+1];
  logic [OP_W-1:0]    op_in [LV+1];
  logic [TAG_W-1:0]   tg_in [LV+1];
  logic               vl_in [LV+1];
  logic [SHAMT_W-1:0] sh_in [LV];
  logic               sg_in [LV];
  logic [WIDTH-1:0]   d_out [LV];

  logic stall;

  assign stall    = vl_in[LV] && !out_ready;
  assign in_ready = !stall;

  assign d_in[0]  = in_data;
  assign op_in[0] = in_op;
  assign tg_in[0] = in_tag;
  assign vl_in[0] = in_valid;
  assign sh_in[0] = in_shamt;
  assign sg_in[0] = in_data[WIDTH-1];

  for (genvar k = 0; k < LV; k++) begin : g_lv
    shift_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_level (
      .data   (d_in[k]),
      .op     (op_in[k]),
      .en     (sh_in[k][0]),
      .sign   (sg_in[k]),
      .result (d_out[k])
    );

    if (k < LV-1) begin : g_mid
      if (PIPE != 0) begin : g_reg
        logic [WIDTH-1:0]   r_data;
        logic [SHAMT_W-1:0] r_shamt;
        logic [OP_W-1:0]    r_op;
        logic [TAG_W-1:0]   r_tag;
        logic               r_sign;
        logic               r_valid;

        always_ff @(posedge clk) begin
          if (rst) begin
            r_data  <= '0;
            r_shamt <= '0;
            r_op    <= '0;
            r_tag   <= '0;
            r_sign  <= 1'b0;
            r_valid <= 1'b0;
          end else if (!stall) begin
            r_data  <= d_out[k];
            r_shamt <= sh_in[k] >> 1;
            r_op    <= op_in[k];
            r_tag   <= tg_in[k];
            r_sign  <= sg_in[k];
            r_valid <= vl_in[k];
          end
        end

        assign d_in[k+1]  = r_data;
        assign sh_in[k+1] = r_shamt;
        assign op_in[k+1] = r_op;
        assign tg_in[k+1] = r_tag;
        assign sg_in[k+1] = r_sign;
        assign vl_in[k+1] = r_valid;
      end else begin : g_comb
        // consumed shamt bit is dropped so the next level always looks at bit 0
        assign d_in[k+1]  = d_out[k];
        assign sh_in[k+1] = sh_in[k] >> 1;
        assign op_in[k+1] = op_in[k];
        assign tg_in[k+1] = tg_in[k];
        assign sg_in[k+1] = sg_in[k];
        assign vl_in[k+1] = vl_in[k];
      end
    end else begin : g_out
      logic [WIDTH-1:0] r_data;
      logic [OP_W-1:0]  r_op;
      logic [TAG_W-1:0] r_tag;
      logic             r_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_data  <= '0;
          r_op    <= '0;
          r_tag   <= '0;
          r_valid <= 1'b0;
        end else if (!stall) begin
          r_data  <= d_out[k];
          r_op    <= op_in[k];
          r_tag   <= tg_in[k];
          r_valid <= vl_in[k];
        end
      end

      assign d_in[LV]  = r_data;
      assign op_in[LV] = r_op;
      assign tg_in[LV] = r_tag;
      assign vl_in[LV] = r_valid;
    end
  end

  assign out_valid = vl_in[LV];
  assign out_data  = d_in[LV];
  assign out_tag   = tg_in[LV];
  assign out_err   = vl_in[LV] && is_reserved_op(op_in[LV]);

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Directed self-checking bench: 32-bit PIPE=0, 32-bit PIPE=1 and 8-bit instances on a shared clock.
module tb_pipe_barrel_shifter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 32-bit, PIPE=0
  logic        p0_in_valid = 1'b0, p0_in_ready, p0_out_valid, p0_out_ready = 1'b1, p0_out_err;
  logic [31:0] p0_in_data = '0, p0_out_data;
  logic [4:0]  p0_in_shamt = '0;
  logic [2:0]  p0_in_op = '0;
  logic [3:0]  p0_in_tag = '0, p0_out_tag;

  // 32-bit, PIPE=1
  logic        p1_in_valid = 1'b0, p1_in_ready, p1_out_valid, p1_out_ready = 1'b1, p1_out_err;
  logic [31:0] p1_in_data = '0, p1_out_data;
  logic [4:0]  p1_in_shamt = '0;
  logic [2:0]  p1_in_op = '0;
  logic [3:0]  p1_in_tag = '0, p1_out_tag;

  // 8-bit, PIPE=0
  logic        b8_in_valid = 1'b0, b8_in_ready, b8_out_valid, b8_out_ready = 1'b1, b8_out_err;
  logic [7:0]  b8_in_data = '0, b8_out_data;
  logic [2:0]  b8_in_shamt = '0;
  logic [2:0]  b8_in_op = '0;
  logic [3:0]  b8_in_tag = '0, b8_out_tag;

  pipe_barrel_shifter #(.WIDTH(32), .PIPE(0), .TAG_W(4)) u_p0 (
    .clk(clk), .rst(rst),
    .in_valid(p0_in_valid), .in_ready(p0_in_ready), .in_data(p0_in_data),
    .in_shamt(p0_in_shamt), .in_op(p0_in_op), .in_tag(p0_in_tag),
    .out_valid(p0_out_valid), .out_ready(p0_out_ready), .out_data(p0_out_data),
    .out_tag(p0_out_tag), .out_err(p0_out_err)
  );

  pipe_barrel_shifter #(.WIDTH(32), .PIPE(1), .TAG_W(4)) u_p1 (
    .clk(clk), .rst(rst),
    .in_valid(p1_in_valid), .in_ready(p1_in_ready), .in_data(p1_in_data),
    .in_shamt(p1_in_shamt), .in_op(p1_in_op), .in_tag(p1_in_tag),
    .out_valid(p1_out_valid), .out_ready(p1_out_ready), .out_data(p1_out_data),
    .out_tag(p1_out_tag), .out_err(p1_out_err)
  );

  pipe_barrel_shifter #(.WIDTH(8), .PIPE(0), .TAG_W(4)) u_b8 (
    .clk(clk), .rst(rst),
    .in_valid(b8_in_valid), .in_ready(b8_in_ready), .in_data(b8_in_data),
    .in_shamt(b8_in_shamt), .in_op(b8_in_op), .in_tag(b8_in_tag),
    .out_valid(b8_out_valid), .out_ready(b8_out_ready), .out_data(b8_out_data),
    .out_tag(b8_out_tag), .out_err(b8_out_err)
  );

  // Bit-by-bit reference, deliberately not structured as shift levels.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int sh,
                                            input logic [2:0] op, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        3'd0:    r[i] = (i >= sh) ? d[i-sh] : 1'b0;
        3'd1:    r[i] = (i + sh < w) ? d[i+sh] : 1'b0;
        3'd2:    r[i] = (i + sh < w) ? d[i+sh] : d[w-1];
        3'd3:    r[i] = d[(i - sh + w) % w];
        3'd4:    r[i] = d[(i + sh) % w];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    p0_in_valid = 1'b1; p0_in_data = 32'h1234_5678; p0_in_shamt = 5'd3; p0_in_tag = 4'hA;
    step();
    step();
    checks++; if (p0_out_valid !== 1'b0) begin errors++; $display("FAIL reset_p0_valid got=%b exp=0", p0_out_valid); end
    checks++; if (p0_out_data !== 32'h0) begin errors++; $display("FAIL reset_p0_data got=%h exp=0", p0_out_data); end
    checks++; if (p0_out_tag !== 4'h0) begin errors++; $display("FAIL reset_p0_tag got=%h exp=0", p0_out_tag); end
    checks++; if (p0_out_err !== 1'b0) begin errors++; $display("FAIL reset_p0_err got=%b exp=0", p0_out_err); end
    checks++; if (p0_in_ready !== 1'b1) begin errors++; $display("FAIL reset_p0_ready got=%b exp=1", p0_in_ready); end
    checks++; if (p1_out_valid !== 1'b0) begin errors++; $display("FAIL reset_p1_valid got=%b exp=0", p1_out_valid); end
    checks++; if (p1_out_data !== 32'h0) begin errors++; $display("FAIL reset_p1_data got=%h exp=0", p1_out_data); end
    p0_in_valid = 1'b0;
    rst = 1'b0;
    step();
    checks++; if (p0_in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_p0_ready got=%b exp=1", p0_in_ready); end
    checks++; if (p1_in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_p1_ready got=%b exp=1", p1_in_ready); end
    checks++; if (p0_out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_p0_valid got=%b exp=0", p0_out_valid); end
  endtask

  task automatic test_pipe0();
    logic [31:0] d, exp;
    logic [4:0]  sh;
    logic [2:0]  op;
    for (int v = 0; v < 3; v++) begin
      case (v)
        0:       begin d = 32'h8000_0001; sh = 5'd1;  op = 3'd0; exp = 32'h0000_0002; end
        1:       begin d = 32'h8000_0000; sh = 5'd31; op = 3'd2; exp = 32'hFFFF_FFFF; end
        default: begin d = 32'h8000_0000; sh = 5'd31; op = 3'd1; exp = 32'h0000_0001; end
      endcase
      p0_in_valid = 1'b1; p0_in_data = d; p0_in_shamt = sh; p0_in_op = op; p0_in_tag = 4'(v + 1);
      step();
      p0_in_valid = 1'b0;
      checks++; if (p0_out_valid !== 1'b1) begin errors++; $display("FAIL p0_valid[%0d] got=%b exp=1", v, p0_out_valid); end
      checks++; if (p0_out_data !== exp) begin errors++; $display("FAIL p0_data[%0d] got=%h exp=%h", v, p0_out_data, exp); end
      checks++; if (p0_out_tag !== 4'(v + 1) || p0_out_err !== 1'b0) begin
        errors++; $display("FAIL p0_tag_err[%0d] got=%h/%b exp=%h/0", v, p0_out_tag, p0_out_err, 4'(v + 1));
      end
      step();
      checks++; if (p0_out_valid !== 1'b0) begin errors++; $display("FAIL p0_bubble[%0d] got=%b exp=0", v, p0_out_valid); end
    end
  endtask

  task automatic test_pipe1_latency();
    logic [31:0] d, exp;
    logic [4:0]  sh;
    logic [2:0]  op;
    logic [3:0]  tg;
    int lat;
    for (int v = 0; v < 2; v++) begin
      if (v == 0) begin d = 32'h0000_00F1; sh = 5'd4; op = 3'd4; tg = 4'h5; exp = 32'h1000_000F; end
      else        begin d = 32'h8000_0001; sh = 5'd1; op = 3'd3; tg = 4'h9; exp = 32'h0000_0003; end
      p1_in_valid = 1'b1; p1_in_data = d; p1_in_shamt = sh; p1_in_op = op; p1_in_tag = tg;
      step();
      p1_in_valid = 1'b0;
      lat = 1;
      while (!p1_out_valid && lat < 20) begin
        step();
        lat++;
      end
      checks++; if (lat !== 5) begin errors++; $display("FAIL p1_latency[%0d] got=%0d exp=5", v, lat); end
      checks++; if (p1_out_data !== exp) begin errors++; $display("FAIL p1_data[%0d] got=%h exp=%h", v, p1_out_data, exp); end
      checks++; if (p1_out_tag !== tg) begin errors++; $display("FAIL p1_tag[%0d] got=%h exp=%h", v, p1_out_tag, tg); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] qd[$];
    logic [3:0]  qt[$];
    logic        qe[$];
    logic [31:0] d;
    logic [2:0]  op;
    logic [4:0]  sh;
    int got = 0;
    int last_cyc = -1;
    int gaps = 0;
    p1_out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c < 20) begin
        d  = $urandom;
        op = 3'($urandom_range(0, 4));
        sh = 5'($urandom_range(0, 31));
        p1_in_valid = 1'b1; p1_in_data = d; p1_in_op = op; p1_in_shamt = sh; p1_in_tag = 4'(c);
        qd.push_back(ref_shift({32'h0, d}, int'(sh), op, 32) & 64'hFFFF_FFFF);
        qt.push_back(4'(c));
        qe.push_back(1'b0);
      end else begin
        p1_in_valid = 1'b0;
      end
      step();
      if (p1_out_valid) begin
        if (last_cyc >= 0 && c != last_cyc + 1) gaps++;
        last_cyc = c;
        checks++;
        if (qd.size() == 0) begin
          errors++; $display("FAIL b2b_extra got=%h exp=none", p1_out_data);
        end else begin
          if (p1_out_data !== qd[0] || p1_out_tag !== qt[0] || p1_out_err !== qe[0]) begin
            errors++;
            $display("FAIL b2b_result[%0d] got=%h/%h/%b exp=%h/%h/%b", got, p1_out_data, p1_out_tag,
                     p1_out_err, qd[0], qt[0], qe[0]);
          end
          void'(qd.pop_front()); void'(qt.pop_front()); void'(qe.pop_front());
        end
        got++;
      end
    end
    p1_in_valid = 1'b0;
    checks++; if (got !== 20) begin errors++; $display("FAIL b2b_count got=%0d exp=20", got); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL b2b_consecutive got=%0d gaps exp=0", gaps); end
  endtask

  task automatic test_backpressure();
    logic [31:0] qd[$];
    logic [3:0]  qt[$];
    logic [31:0] d, held_d;
    logic [3:0]  held_t;
    logic [2:0]  op;
    logic [4:0]  sh;
    int issued = 0;
    int got = 0;
    int stall_n = 0;
    for (int c = 0; c < 40; c++) begin
      p1_out_ready = !(c >= 7 && c < 10);
      if (issued < 8) begin
        d  = 32'h0F0F_1234 ^ (32'(issued) * 32'h0101_0101);
        op = 3'(issued % 5);
        sh = 5'(issued * 3 + 1);
        p1_in_valid = 1'b1; p1_in_data = d; p1_in_op = op; p1_in_shamt = sh; p1_in_tag = 4'(issued);
      end else begin
        p1_in_valid = 1'b0;
      end
      #1;
      if (p1_out_valid && !p1_out_ready) begin
        checks++; if (p1_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", c, p1_in_ready); end
        if (stall_n == 0) begin
          held_d = p1_out_data;
          held_t = p1_out_tag;
        end else begin
          checks++;
          if (p1_out_data !== held_d || p1_out_tag !== held_t) begin
            errors++; $display("FAIL bp_stable[%0d] got=%h/%h exp=%h/%h", c, p1_out_data, p1_out_tag, held_d, held_t);
          end
        end
        stall_n++;
      end
      if (p1_out_valid && p1_out_ready) begin
        checks++;
        if (qd.size() == 0) begin
          errors++; $display("FAIL bp_extra got=%h exp=none", p1_out_data);
        end else begin
          if (p1_out_data !== qd[0] || p1_out_tag !== qt[0]) begin
            errors++; $display("FAIL bp_result[%0d] got=%h/%h exp=%h/%h", got, p1_out_data, p1_out_tag, qd[0], qt[0]);
          end
          void'(qd.pop_front()); void'(qt.pop_front());
        end
        got++;
      end
      if (p1_in_valid && p1_in_ready) begin
        qd.push_back(ref_shift({32'h0, d}, int'(sh), op, 32) & 64'hFFFF_FFFF);
        qt.push_back(4'(issued));
        issued++;
      end
      @(posedge clk);
      #1;
    end
    p1_in_valid = 1'b0;
    p1_out_ready = 1'b1;
    checks++; if (got !== 8) begin errors++; $display("FAIL bp_count got=%0d exp=8", got); end
    checks++; if (stall_n !== 3) begin errors++; $display("FAIL bp_stall_cycles got=%0d exp=3", stall_n); end
  endtask

  task automatic test_edge();
    logic [2:0] op;
    logic [4:0] sh;
    for (int v = 0; v < 7; v++) begin
      op = (v < 5) ? 3'(v) : ((v == 5) ? 3'b111 : 3'b101);
      sh = (v < 5) ? 5'd0 : ((v == 5) ? 5'd5 : 5'd9);
      p0_in_valid = 1'b1; p0_in_data = 32'hDEAD_BEEF; p0_in_shamt = sh; p0_in_op = op; p0_in_tag = 4'(v);
      step();
      p0_in_valid = 1'b0;
      checks++; if (p0_out_valid !== 1'b1 || p0_out_data !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL edge_data[op=%0d] got=%b/%h exp=1/deadbeef", op, p0_out_valid, p0_out_data);
      end
      checks++; if (p0_out_err !== (v >= 5)) begin
        errors++; $display("FAIL edge_err[op=%0d] got=%b exp=%b", op, p0_out_err, (v >= 5));
      end
    end
    step();
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    int lat;
    p1_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p1_in_valid = 1'b1; p1_in_data = 32'hA5A5_0000 + 32'(i); p1_in_shamt = 5'(i + 2);
      p1_in_op = 3'd0; p1_in_tag = 4'(i + 12);
      step();
    end
    p1_in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (p1_out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", p1_out_valid); end
    for (int i = 0; i < 8; i++) begin
      step();
      if (p1_out_valid) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL rst_mid_stale got=%0d exp=0", stale); end
    p1_in_valid = 1'b1; p1_in_data = 32'h0000_00F1; p1_in_shamt = 5'd4; p1_in_op = 3'd4; p1_in_tag = 4'h3;
    step();
    p1_in_valid = 1'b0;
    lat = 1;
    while (!p1_out_valid && lat < 20) begin
      step();
      lat++;
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL rst_mid_latency got=%0d exp=5", lat); end
    checks++; if (p1_out_data !== 32'h1000_000F || p1_out_tag !== 4'h3) begin
      errors++; $display("FAIL rst_mid_result got=%h/%h exp=1000000f/3", p1_out_data, p1_out_tag);
    end
    step();
  endtask

  task automatic test_width8_sweep();
    int bad = 0;
    logic [7:0] exp;
    for (int d = 0; d < 256; d++) begin
      for (int sh = 0; sh < 8; sh++) begin
        for (int op = 0; op < 8; op++) begin
          b8_in_valid = 1'b1; b8_in_data = 8'(d); b8_in_shamt = 3'(sh); b8_in_op = 3'(op); b8_in_tag = 4'(d);
          step();
          exp = 8'(ref_shift(64'(d), sh, 3'(op), 8));
          if (b8_out_valid !== 1'b1 || b8_out_data !== exp || b8_out_tag !== 4'(d) || b8_out_err !== (op > 4))
            bad++;
        end
      end
    end
    b8_in_valid = 1'b0;
    step();
    checks++; if (bad !== 0) begin errors++; $display("FAIL w8_sweep got=%0d bad exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_pipe0();
    test_pipe1_latency();
    test_back_to_back();
    test_backpressure();
    test_edge();
    test_reset_midstream();
    test_width8_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
